// File: rtl/pipe_trace_monitor.sv
// pipe_trace_monitor
//   Observes the write-back stage of the RISC-V pipeline and keeps eight
//   saturating event counters plus a first-word-fall-through trace FIFO of
//   retired instructions. The FIFO is drained over a valid/ready stream.
//
// Ports
//   clk               system clock, rising edge
//   reset             asynchronous active-low reset
//   i_enable          1 = count and capture, 0 = freeze (pops still allowed)
//   i_clear           synchronous clear of counters, FIFO and overflow flag
//   i_pc_wb           PC of the instruction in WB
//   i_instr_wb        instruction word in WB
//   i_stall           load-use stall this cycle
//   i_flush           branch/jump flush this cycle
//   i_forwardA/B      forwarding selects for ALU operands A/B
//   i_mem_write       store strobe
//   i_sel             counter select for o_count
//   o_count           selected counter value
//   o_trace_valid     FIFO non-empty
//   i_trace_ready     consumer accepts the head entry
//   o_trace_pc        head entry PC (0 while empty)
//   o_trace_instr     head entry instruction (0 while empty)
//   o_trace_level     current FIFO occupancy
//   o_trace_overflow  sticky: a retired instruction was dropped
`timescale 1ns/1ps

module pipe_trace_monitor #(
    parameter int CNT_W      = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_enable,
    input  logic                          i_clear,
    input  logic [31:0]                   i_pc_wb,
    input  logic [31:0]                   i_instr_wb,
    input  logic                          i_stall,
    input  logic                          i_flush,
    input  logic [1:0]                    i_forwardA,
    input  logic [1:0]                    i_forwardB,
    input  logic                          i_mem_write,
    input  logic [2:0]                    i_sel,
    output logic [CNT_W-1:0]              o_count,
    output logic                          o_trace_valid,
    input  logic                          i_trace_ready,
    output logic [31:0]                   o_trace_pc,
    output logic [31:0]                   o_trace_instr,
    output logic [$clog2(FIFO_DEPTH):0]   o_trace_level,
    output logic                          o_trace_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [AW-1:0]    PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0]    LVL_ONE  = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0]    LVL_FULL = LW'(FIFO_DEPTH);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    logic       retire;
    logic [6:0] opcode;
    logic [7:0] ev;

    always_comb begin
        opcode = i_instr_wb[6:0];
        // Bubbles (all zero) and canonical NOPs (addi x0,x0,0) are not work.
        retire = (i_instr_wb != 32'h0000_0000) && (i_instr_wb != 32'h0000_0013);
        ev     = '0;
        ev[0]  = 1'b1;
        ev[1]  = retire;
        ev[2]  = i_stall;
        ev[3]  = i_flush;
        ev[4]  = (i_forwardA != 2'b00) || (i_forwardB != 2'b00);
        ev[5]  = i_mem_write;
        ev[6]  = retire && (opcode == OP_LOAD);
        ev[7]  = retire && ((opcode == OP_BRANCH) || (opcode == OP_JAL) ||
                            (opcode == OP_JALR));
    end

    // ------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = cnt_q[i];
            if (i_clear) begin
                cnt_d[i] = '0;
            end else if (i_enable && ev[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign o_count = cnt_q[i_sel];

    // ------------------------------------------------------------------
    // Trace FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic          overflow_q, overflow_d;
    logic [63:0]   mem_q [FIFO_DEPTH];

    logic empty, full, push, pop, wr_en, drop;
    logic [63:0] head;

    always_comb begin
        empty = (level_q == '0);
        full  = (level_q == LVL_FULL);
        push  = i_enable && retire && !i_clear;
        pop   = !empty && i_trace_ready && !i_clear;
        // A full FIFO still accepts a push when the head leaves the same cycle.
        wr_en = push && (!full || pop);
        drop  = push && full && !pop;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q | drop;

        if (i_clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({wr_en, pop})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset: stale words are never visible because the
    // outputs are gated by the occupancy, which reset and clear zero.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {i_pc_wb, i_instr_wb};
        end
    end

    assign head             = mem_q[rd_ptr_q];
    assign o_trace_valid    = !empty;
    assign o_trace_pc       = empty ? 32'h0 : head[63:32];
    assign o_trace_instr    = empty ? 32'h0 : head[31:0];
    assign o_trace_level    = level_q;
    assign o_trace_overflow = overflow_q;

endmodule

// File: tb/tb_pipe_trace_monitor.sv
`timescale 1ns/1ps

module tb_pipe_trace_monitor;

    localparam int CW    = 8;
    localparam int DEPTH = 8;
    localparam int LW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_enable, i_clear;
    logic [31:0]   i_pc_wb, i_instr_wb;
    logic          i_stall, i_flush, i_mem_write;
    logic [1:0]    i_forwardA, i_forwardB;
    logic [2:0]    i_sel;
    logic [CW-1:0] o_count;
    logic          o_trace_valid, i_trace_ready;
    logic [31:0]   o_trace_pc, o_trace_instr;
    logic [LW-1:0] o_trace_level;
    logic          o_trace_overflow;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    always #10 clk = ~clk;

    pipe_trace_monitor #(.CNT_W(CW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .i_enable(i_enable), .i_clear(i_clear),
        .i_pc_wb(i_pc_wb), .i_instr_wb(i_instr_wb), .i_stall(i_stall),
        .i_flush(i_flush), .i_forwardA(i_forwardA), .i_forwardB(i_forwardB),
        .i_mem_write(i_mem_write), .i_sel(i_sel), .o_count(o_count),
        .o_trace_valid(o_trace_valid), .i_trace_ready(i_trace_ready),
        .o_trace_pc(o_trace_pc), .o_trace_instr(o_trace_instr),
        .o_trace_level(o_trace_level), .o_trace_overflow(o_trace_overflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_enable = 0; i_clear = 0; i_pc_wb = 0; i_instr_wb = 0;
        i_stall = 0; i_flush = 0; i_forwardA = 0; i_forwardB = 0;
        i_mem_write = 0; i_trace_ready = 0;
    endtask

    task automatic do_clear();
        i_clear = 1;
        step();
        i_clear = 0;
        exp_q.delete();
    endtask

    // Drive one retiring instruction for a cycle; the bench records it as
    // expected FIFO content when it should be accepted.
    task automatic drive_retire(input logic [31:0] pc, input logic [31:0] ins, input bit accept);
        i_enable = 1; i_pc_wb = pc; i_instr_wb = ins;
        if (accept) exp_q.push_back({pc, ins});
    endtask

    task automatic test_reset();
        logic [CW-1:0] e [8] = '{default: '0};
        idle(); i_sel = 0;
        #2 reset = 0;
        #25 reset = 1;
        step();
        checks++; if (o_trace_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", o_trace_valid); end
        checks++; if (o_trace_level !== 0) begin failures++; $display("FAIL reset_level got=%0d exp=0", o_trace_level); end
        checks++; if (o_trace_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", o_trace_overflow); end
        checks++; if (o_trace_pc !== 0 || o_trace_instr !== 0) begin failures++; $display("FAIL reset_head got=%h/%h exp=0/0", o_trace_pc, o_trace_instr); end
        for (int s = 0; s < 8; s++) begin
            i_sel = 3'(s); #1;
            checks++; if (o_count !== e[s]) begin failures++; $display("FAIL reset_cnt%0d got=%0d exp=%0d", s, o_count, e[s]); end
        end
    endtask

    task automatic test_nop_cycles();
        logic [CW-1:0] e [8] = '{8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        do_clear();
        i_enable = 1; i_instr_wb = 32'h0000_0013;
        repeat (10) step();
        idle();
        checks++; if (o_trace_valid !== 1'b0) begin failures++; $display("FAIL nop_valid got=%0b exp=0", o_trace_valid); end
        for (int s = 0; s < 8; s++) begin
            i_sel = 3'(s); #1;
            checks++; if (o_count !== e[s]) begin failures++; $display("FAIL nop_cnt%0d got=%0d exp=%0d", s, o_count, e[s]); end
        end
    endtask

    task automatic test_two_retire();
        logic [CW-1:0] e [8] = '{8'd3, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1};
        logic [63:0] x;
        int n;
        do_clear();
        drive_retire(32'h0, 32'h0050_0093, 1);
        step();
        checks++; if (o_trace_valid !== 1'b1) begin failures++; $display("FAIL two_latency_valid got=%0b exp=1", o_trace_valid); end
        drive_retire(32'h4, 32'h0000_a103, 1);
        step();
        drive_retire(32'h8, 32'h0000_0063, 1);
        step();
        idle();
        checks++; if (o_trace_level !== 3) begin failures++; $display("FAIL two_level got=%0d exp=3", o_trace_level); end
        checks++; if (o_trace_pc !== 32'h0 || o_trace_instr !== 32'h0050_0093) begin failures++; $display("FAIL two_head got=%h/%h exp=00000000/00500093", o_trace_pc, o_trace_instr); end
        for (int s = 0; s < 8; s++) begin
            i_sel = 3'(s); #1;
            checks++; if (o_count !== e[s]) begin failures++; $display("FAIL two_cnt%0d got=%0d exp=%0d", s, o_count, e[s]); end
        end
        i_trace_ready = 1; n = 0;
        while (o_trace_valid && n < DEPTH + 4) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL two_drain_extra got=%h/%h exp=none", o_trace_pc, o_trace_instr); end
            else begin x = exp_q.pop_front(); if ({o_trace_pc, o_trace_instr} !== x) begin failures++; $display("FAIL two_drain got=%h/%h exp=%h", o_trace_pc, o_trace_instr, x); end end
            step(); n++;
        end
        i_trace_ready = 0;
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL two_drain_missing got=%0d exp=0 remaining", exp_q.size()); end
        checks++; if (o_trace_pc !== 0 || o_trace_instr !== 0) begin failures++; $display("FAIL two_empty_head got=%h/%h exp=0/0", o_trace_pc, o_trace_instr); end
    endtask

    task automatic test_overflow();
        logic [63:0] x;
        int n;
        do_clear();
        for (int i = 0; i <= DEPTH; i++) begin
            drive_retire(32'h100 + 32'(4 * i), {12'(i + 1), 20'h00093}, i < DEPTH);
            step();
            checks++; if (o_trace_overflow !== (i == DEPTH)) begin failures++; $display("FAIL ovf_flag_%0d got=%0b exp=%0b", i, o_trace_overflow, (i == DEPTH)); end
        end
        idle();
        checks++; if (o_trace_level !== LW'(DEPTH)) begin failures++; $display("FAIL ovf_level got=%0d exp=%0d", o_trace_level, DEPTH); end
        i_sel = 3'd1; #1;
        checks++; if (o_count !== 8'd9) begin failures++; $display("FAIL ovf_retired got=%0d exp=9", o_count); end
        i_trace_ready = 1; n = 0;
        while (o_trace_valid && n < DEPTH + 4) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL ovf_drain_extra got=%h/%h exp=none", o_trace_pc, o_trace_instr); end
            else begin x = exp_q.pop_front(); if ({o_trace_pc, o_trace_instr} !== x) begin failures++; $display("FAIL ovf_drain got=%h/%h exp=%h", o_trace_pc, o_trace_instr, x); end end
            step(); n++;
        end
        i_trace_ready = 0;
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL ovf_drain_missing got=%0d exp=0 remaining", exp_q.size()); end
        checks++; if (o_trace_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", o_trace_overflow); end
        do_clear();
        checks++; if (o_trace_overflow !== 1'b0) begin failures++; $display("FAIL ovf_cleared got=%0b exp=0", o_trace_overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [63:0] x;
        int n;
        do_clear();
        for (int i = 0; i < DEPTH; i++) begin
            drive_retire(32'h200 + 32'(4 * i), {12'(i + 32), 20'h00093}, 1);
            step();
        end
        drive_retire(32'h300, 32'h7ff0_0093, 1);
        i_trace_ready = 1;
        checks++;
        x = exp_q.pop_front();
        if ({o_trace_pc, o_trace_instr} !== x) begin failures++; $display("FAIL fpp_head got=%h/%h exp=%h", o_trace_pc, o_trace_instr, x); end
        step();
        idle();
        checks++; if (o_trace_level !== LW'(DEPTH)) begin failures++; $display("FAIL fpp_level got=%0d exp=%0d", o_trace_level, DEPTH); end
        checks++; if (o_trace_overflow !== 1'b0) begin failures++; $display("FAIL fpp_overflow got=%0b exp=0", o_trace_overflow); end
        i_trace_ready = 1; n = 0;
        while (o_trace_valid && n < DEPTH + 4) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL fpp_drain_extra got=%h/%h exp=none", o_trace_pc, o_trace_instr); end
            else begin x = exp_q.pop_front(); if ({o_trace_pc, o_trace_instr} !== x) begin failures++; $display("FAIL fpp_drain got=%h/%h exp=%h", o_trace_pc, o_trace_instr, x); end end
            step(); n++;
        end
        i_trace_ready = 0;
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL fpp_drain_missing got=%0d exp=0 remaining", exp_q.size()); end
    endtask

    task automatic test_empty_push_pop();
        do_clear();
        drive_retire(32'h400, 32'h0000_006f, 1);
        i_trace_ready = 1;
        step();
        idle();
        checks++; if (o_trace_level !== 1) begin failures++; $display("FAIL epp_level got=%0d exp=1", o_trace_level); end
        checks++; if ({o_trace_pc, o_trace_instr} !== exp_q[0]) begin failures++; $display("FAIL epp_head got=%h/%h exp=%h", o_trace_pc, o_trace_instr, exp_q[0]); end
        i_sel = 3'd7; #1;
        checks++; if (o_count !== 8'd1) begin failures++; $display("FAIL epp_ctrl got=%0d exp=1", o_count); end
        i_trace_ready = 1; step(); i_trace_ready = 0;
        exp_q.delete();
        checks++; if (o_trace_valid !== 1'b0) begin failures++; $display("FAIL epp_drained got=%0b exp=0", o_trace_valid); end
    endtask

    task automatic test_events();
        logic [CW-1:0] e [8] = '{8'd3, 8'd0, 8'd3, 8'd3, 8'd3, 8'd1, 8'd0, 8'd0};
        do_clear();
        i_enable = 1; i_stall = 1; i_flush = 1; i_forwardA = 2'b10; i_forwardB = 2'b01;
        i_mem_write = 1;
        step();
        i_mem_write = 0;
        repeat (2) step();
        // Frozen: nothing below may count or push.
        idle();
        i_stall = 1; i_flush = 1; i_mem_write = 1; i_forwardA = 2'b11; i_instr_wb = 32'h0050_0093;
        repeat (2) step();
        idle();
        checks++; if (o_trace_level !== 0) begin failures++; $display("FAIL ev_frozen_level got=%0d exp=0", o_trace_level); end
        for (int s = 0; s < 8; s++) begin
            i_sel = 3'(s); #1;
            checks++; if (o_count !== e[s]) begin failures++; $display("FAIL ev_cnt%0d got=%0d exp=%0d", s, o_count, e[s]); end
        end
    endtask

    task automatic test_clear_priority();
        do_clear();
        drive_retire(32'h500, 32'h0010_0093, 1); step();
        drive_retire(32'h504, 32'h0020_0093, 1); step();
        drive_retire(32'h508, 32'h0030_0093, 0);
        i_clear = 1; i_trace_ready = 1; i_stall = 1;
        step();
        idle();
        exp_q.delete();
        checks++; if (o_trace_level !== 0 || o_trace_valid !== 1'b0) begin failures++; $display("FAIL clr_fifo got=%0d/%0b exp=0/0", o_trace_level, o_trace_valid); end
        checks++; if (o_trace_pc !== 0 || o_trace_instr !== 0) begin failures++; $display("FAIL clr_head got=%h/%h exp=0/0", o_trace_pc, o_trace_instr); end
        for (int s = 0; s < 8; s++) begin
            i_sel = 3'(s); #1;
            checks++; if (o_count !== 0) begin failures++; $display("FAIL clr_cnt%0d got=%0d exp=0", s, o_count); end
        end
    endtask

    task automatic test_async_reset();
        do_clear();
        for (int i = 0; i < 3; i++) begin
            drive_retire(32'h600 + 32'(4 * i), {12'(i + 5), 20'h00093}, 1);
            step();
        end
        idle();
        i_sel = 3'd0;
        #4;
        reset = 0;
        #0.5;
        checks++; if (o_trace_valid !== 1'b0 || o_trace_level !== 0) begin failures++; $display("FAIL arst_fifo got=%0b/%0d exp=0/0", o_trace_valid, o_trace_level); end
        checks++; if (o_trace_pc !== 0 || o_trace_instr !== 0) begin failures++; $display("FAIL arst_head got=%h/%h exp=0/0", o_trace_pc, o_trace_instr); end
        checks++; if (o_count !== 0) begin failures++; $display("FAIL arst_cnt0 got=%0d exp=0", o_count); end
        #0.5;
        reset = 1;
        exp_q.delete();
        step();
        checks++; if (o_trace_valid !== 1'b0 || o_trace_overflow !== 1'b0) begin failures++; $display("FAIL arst_after got=%0b/%0b exp=0/0", o_trace_valid, o_trace_overflow); end
    endtask

    task automatic test_saturate();
        do_clear();
        i_enable = 1; i_instr_wb = 32'h0000_0013;
        repeat (254) step();
        i_enable = 0; i_sel = 3'd0; #1;
        checks++; if (o_count !== 8'hFE) begin failures++; $display("FAIL sat_pre got=%0h exp=fe", o_count); end
        i_enable = 1;
        repeat (3) step();
        i_enable = 0; #1;
        checks++; if (o_count !== 8'hFF) begin failures++; $display("FAIL sat_hold got=%0h exp=ff", o_count); end
        idle();
    endtask

    initial begin
        idle();
        i_sel = 0;
        test_reset();
        test_nop_cycles();
        test_two_retire();
        test_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_events();
        test_clear_priority();
        test_async_reset();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
